// File: rtl/light_sequencer_if.sv
// Timer handshake between the light sequencer (master) and the delay timer (slave).
// The master pulses trL/trS to request a delay; the timer answers with tL/tS.
interface light_sequencer_if;
  logic trL;
  logic trS;
  logic tL;
  logic tS;

  modport master (output trL, output trS, input tL, input tS);
  modport slave  (input trL, input trS, output tL, output tS);
endinterface

// File: rtl/light_sequencer.sv
// Two-road junction sequencer: requests long/short delays from a paired timer,
// advances on its done pulses, and traps a silent timer into FAULT.
module light_sequencer #(
  parameter int TIMEOUT = 64,
  parameter int WD_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              car_side,
  light_sequencer_if.master tmr,
  output logic [2:0]        main_light,
  output logic [2:0]        side_light,
  output logic              fault
);

  typedef enum logic [2:0] {
    MAIN_G, MAIN_Y, RED1, SIDE_G, SIDE_Y, RED2, FAULT
  } state_t;

  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  state_t          r_state;
  logic            r_min_done;
  logic            r_side_req;
  logic            r_pending;
  logic            r_trL;
  logic            r_trS;
  logic            r_fault;
  logic [WD_W-1:0] r_wd;

  state_t w_next;
  logic   w_next_long;
  logic   w_await;
  logic   w_done_ok;

  // Successor of each timed state and the kind of delay it asks for on entry.
  always_comb begin
    w_next      = FAULT;
    w_next_long = 1'b0;
    case (r_state)
      MAIN_Y:  w_next = RED1;
      RED1: begin
        w_next      = SIDE_G;
        w_next_long = 1'b1;
      end
      SIDE_G:  w_next = SIDE_Y;
      SIDE_Y:  w_next = RED2;
      RED2: begin
        w_next      = MAIN_G;
        w_next_long = 1'b1;
      end
      default: w_next = FAULT;
    endcase
  end

  // A done is awaited only after a request is out; MAIN_G idles once min_done is set.
  assign w_await = !r_pending &&
                   ((r_state == MAIN_G && !r_min_done) ||
                    (r_state inside {MAIN_Y, RED1, SIDE_G, SIDE_Y, RED2}));
  assign w_done_ok = (r_state == MAIN_G || r_state == SIDE_G) ? tmr.tL : tmr.tS;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= MAIN_G;
      r_min_done <= 1'b0;
      r_side_req <= 1'b0;
      r_pending  <= 1'b1;
      r_trL      <= 1'b0;
      r_trS      <= 1'b0;
      r_fault    <= 1'b0;
      r_wd       <= '0;
    end else begin
      r_trL <= 1'b0;
      r_trS <= 1'b0;
      if (car_side && r_state != SIDE_G)
        r_side_req <= 1'b1;

      if (r_pending) begin
        r_pending <= 1'b0;
        r_trL     <= 1'b1;
        r_wd      <= '0;
      end else if (w_await) begin
        if (w_done_ok) begin
          if (r_state == MAIN_G) begin
            r_min_done <= 1'b1;
          end else begin
            r_state <= w_next;
            r_trL   <= w_next_long;
            r_trS   <= !w_next_long;
            r_wd    <= '0;
            // Entry side effects override the sticky set above.
            if (w_next == SIDE_G)
              r_side_req <= 1'b0;
            if (w_next == MAIN_G)
              r_min_done <= 1'b0;
          end
        end else if (r_wd == WD_LIMIT) begin
          r_state <= FAULT;
          r_fault <= 1'b1;
        end else begin
          r_wd <= r_wd + WD_W'(1);
        end
      end else if (r_state == MAIN_G && r_min_done && r_side_req) begin
        r_state <= MAIN_Y;
        r_trS   <= 1'b1;
        r_wd    <= '0;
      end
    end
  end

  always_comb begin
    main_light = RED;
    side_light = RED;
    case (r_state)
      MAIN_G:  main_light = GRN;
      MAIN_Y:  main_light = YEL;
      SIDE_G:  side_light = GRN;
      SIDE_Y:  side_light = YEL;
      default: begin
        main_light = RED;
        side_light = RED;
      end
    endcase
  end

  assign tmr.trL = r_trL;
  assign tmr.trS = r_trS;
  assign fault   = r_fault;

endmodule

// File: tb/tb_light_sequencer.sv
// Directed bench for light_sequencer with a delay-timer model (tL 5, tS 2 cycles).
module tb_light_sequencer;

  localparam int LDEL = 5;
  localparam logic [5:0] GR = 6'b001_100;
  localparam logic [5:0] YR = 6'b010_100;
  localparam logic [5:0] RR = 6'b100_100;
  localparam logic [5:0] RG = 6'b100_001;
  localparam logic [5:0] RY = 6'b100_010;

  logic       clk;
  logic       reset;
  logic       car_side;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       fault;

  light_sequencer_if itf ();

  light_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .car_side   (car_side),
    .tmr        (itf),
    .main_light (main_light),
    .side_light (side_light),
    .fault      (fault)
  );

  // Timer model: answers a request edge R with a done sampled at edge R+delay.
  logic mute;
  logic spur_l;
  logic spur_s;
  int   sdel;
  int   m_cnt_l;
  int   m_cnt_s;
  logic m_fire_l;
  logic m_fire_s;

  initial begin
    m_cnt_l  = 0;
    m_cnt_s  = 0;
    m_fire_l = 1'b0;
    m_fire_s = 1'b0;
  end

  always @(negedge clk) begin
    m_fire_l <= (m_cnt_l == 1);
    m_fire_s <= (m_cnt_s == 1);
    if (itf.trL) m_cnt_l <= LDEL - 1;
    else if (m_cnt_l != 0) m_cnt_l <= m_cnt_l - 1;
    if (itf.trS) m_cnt_s <= sdel - 1;
    else if (m_cnt_s != 0) m_cnt_s <= m_cnt_s - 1;
  end

  assign itf.tL = (m_fire_l & ~mute) | spur_l;
  assign itf.tS = (m_fire_s & ~mute) | spur_s;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  logic [8:0] obs;
  assign obs = {main_light, side_light, itf.trL, itf.trS, fault};

  int n_checks = 0;
  int n_err    = 0;
  logic [8:0] t2 [21];

  task automatic chk(input string tag, input logic [8:0] o, input logic [8:0] e);
    n_checks++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, o, e);
    end
  endtask

  task automatic edge_chk(input string tag, input logic [8:0] e);
    @(negedge clk);
    chk(tag, obs, e);
  endtask

  initial begin
    t2 = '{{GR,3'b100}, {GR,3'b000}, {GR,3'b000}, {GR,3'b000}, {GR,3'b000},
           {GR,3'b000}, {YR,3'b010}, {YR,3'b000}, {RR,3'b010}, {RR,3'b000},
           {RG,3'b100}, {RG,3'b000}, {RG,3'b000}, {RG,3'b000}, {RG,3'b000},
           {RY,3'b010}, {RY,3'b000}, {RR,3'b010}, {RR,3'b000}, {GR,3'b100},
           {GR,3'b000}};
    reset    = 1'b1;
    car_side = 1'b0;
    mute     = 1'b0;
    spur_l   = 1'b0;
    spur_s   = 1'b0;
    sdel     = 2;

    // Reset values, then no side traffic: one trL and an idle MAIN_G.
    @(negedge clk);
    chk("reset", obs, {GR, 3'b000});
    reset = 1'b0;
    edge_chk("t1_e1", {GR, 3'b100});
    for (int e = 2; e <= 12; e++)
      edge_chk($sformatf("t1_e%0d", e), {GR, 3'b000});

    // Full loop with car_side pulse at cycle 3 and stray wrong-kind dones.
    #2 reset = 1'b1;
    #1 chk("t2_rst", obs, {GR, 3'b000});
    @(negedge clk);
    reset = 1'b0;
    for (int e = 1; e <= 21; e++) begin
      car_side = (e == 3);
      spur_l   = (e == 8);
      spur_s   = (e == 13);
      edge_chk($sformatf("t2_e%0d", e), t2[e-1]);
    end
    // tL and car_side in the same cycle: MAIN_Y on the following edge.
    for (int e = 22; e <= 26; e++) begin
      car_side = (e == 25);
      spur_l   = 1'b0;
      spur_s   = 1'b0;
      edge_chk($sformatf("t2_e%0d", e), (e == 26) ? {YR, 3'b010} : {GR, 3'b000});
    end

    // Muted timer after trS at edge 26: FAULT at 26+64+1.
    car_side = 1'b0;
    mute     = 1'b1;
    for (int e = 27; e <= 90; e++)
      edge_chk($sformatf("t4_wait_e%0d", e), {YR, 3'b000});
    edge_chk("t4_fault", {RR, 3'b001});
    mute = 1'b0;
    for (int e = 92; e <= 95; e++) begin
      spur_s   = (e == 93);
      spur_l   = (e == 93);
      car_side = (e == 94);
      edge_chk($sformatf("t4_hold_e%0d", e), {RR, 3'b001});
    end
    spur_s   = 1'b0;
    spur_l   = 1'b0;
    car_side = 1'b0;

    // Valid tS in the very cycle wd reaches TIMEOUT.
    sdel = 65;
    #2 reset = 1'b1;
    #1 chk("t5_rst", obs, {GR, 3'b000});
    @(negedge clk);
    reset    = 1'b0;
    car_side = 1'b1;
    edge_chk("t5_e1", {GR, 3'b100});
    car_side = 1'b0;
    for (int e = 2; e <= 6; e++)
      edge_chk($sformatf("t5_e%0d", e), {GR, 3'b000});
    edge_chk("t5_e7", {YR, 3'b010});
    for (int e = 8; e <= 71; e++) begin
      if (e == 71) sdel = 2;
      edge_chk($sformatf("t5_e%0d", e), {YR, 3'b000});
    end
    edge_chk("t5_e72", {RR, 3'b010});
    edge_chk("t5_e73", {RR, 3'b000});
    edge_chk("t5_e74", {RG, 3'b100});

    // Asynchronous reset in SIDE_G; the stale tL lands on post-reset edge 1.
    #2 reset = 1'b1;
    #1 chk("t6_rst_async", obs, {GR, 3'b000});
    repeat (4) @(negedge clk);
    reset    = 1'b0;
    car_side = 1'b1;
    edge_chk("t6_e1", {GR, 3'b100});
    car_side = 1'b0;
    for (int e = 2; e <= 6; e++)
      edge_chk($sformatf("t6_e%0d", e), {GR, 3'b000});
    edge_chk("t6_e7", {YR, 3'b010});

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
